// File: rtl/controle_vez_pkg.sv
// Shared turn-controller constants: state encodings, display codes and the
// state-to-display decoder reused by the player display logic.
package controle_vez_pkg;

  localparam logic [2:0] est_inicial = 3'd0;
  localparam logic [2:0] est_vez_j1  = 3'd1;
  localparam logic [2:0] est_vez_j2  = 3'd2;
  localparam logic [2:0] est_erro    = 3'd3;
  localparam logic [2:0] est_fim     = 3'd4;

  localparam logic [1:0] jog_nenhum = 2'b00;
  localparam logic [1:0] jog_j1     = 2'b01;
  localparam logic [1:0] jog_j2     = 2'b10;
  localparam logic [1:0] jog_erro   = 2'b11;

  typedef struct packed {
    logic [1:0] jogador;
    logic       vez_j1;
    logic       vez_j2;
    logic       em_jogo;
  } saida_t;

  // Counter width for a terminal count, never narrower than one bit
  function automatic int unsigned largura(input int unsigned n);
    return (n > 1) ? $unsigned($clog2(n)) : 1;
  endfunction

  function automatic saida_t decodifica(input logic [2:0] est);
    saida_t s;
    s = '{jogador: jog_nenhum, vez_j1: 1'b0, vez_j2: 1'b0, em_jogo: 1'b0};
    case (est)
      est_vez_j1: s = '{jogador: jog_j1,   vez_j1: 1'b1, vez_j2: 1'b0, em_jogo: 1'b1};
      est_vez_j2: s = '{jogador: jog_j2,   vez_j1: 1'b0, vez_j2: 1'b1, em_jogo: 1'b1};
      est_erro:   s = '{jogador: jog_erro, vez_j1: 1'b0, vez_j2: 1'b0, em_jogo: 1'b1};
      default:    s = '{jogador: jog_nenhum, vez_j1: 1'b0, vez_j2: 1'b0, em_jogo: 1'b0};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/controle_vez_contador_timeout.sv
// Clearable up-counter; fim_c flags the cycle in which the count sits at TERMINAL-1.
module controle_vez_contador_timeout
  import controle_vez_pkg::*;
#(
  parameter int unsigned TERMINAL = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic conta,
  output logic fim_c
);

  localparam int unsigned W = largura(TERMINAL);

  logic [W-1:0] contagem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      contagem <= '0;
    else if (limpa) contagem <= '0;
    else if (conta) contagem <= contagem + W'(1);
  end

  assign fim_c = (contagem == W'(TERMINAL - 1));

endmodule

// File: rtl/controle_vez.sv
// Turn controller for a two-player board game: alternates turns, times out idle
// players, holds an error indication after illegal moves.
module controle_vez
  import controle_vez_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 5000,
  parameter int unsigned ERRO_CICLOS    = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_valida,
  input  logic       jogada_invalida,
  input  logic       fim_jogo,
  output logic [1:0] jogador,
  output logic       vez_j1,
  output logic       vez_j2,
  output logic       timeout,
  output logic       em_jogo
);

  logic [2:0] estado, prox_estado;
  logic       dono_erro, prox_dono;
  logic       quem_comeca, prox_quem;
  logic       prox_timeout;
  logic       turno_fim, erro_fim;
  logic       limpa_turno, limpa_erro;
  logic       em_vez;
  saida_t     prox_saida;

  controle_vez_contador_timeout #(.TERMINAL(TIMEOUT_CICLOS)) u_turno (
    .clock (clock),
    .reset (reset),
    .limpa (limpa_turno),
    .conta (1'b1),
    .fim_c (turno_fim)
  );

  controle_vez_contador_timeout #(.TERMINAL(ERRO_CICLOS)) u_erro (
    .clock (clock),
    .reset (reset),
    .limpa (limpa_erro),
    .conta (1'b1),
    .fim_c (erro_fim)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= est_inicial;
      dono_erro   <= 1'b0;
      quem_comeca <= 1'b0;
    end else begin
      estado      <= prox_estado;
      dono_erro   <= prox_dono;
      quem_comeca <= prox_quem;
    end
  end

  // Next state; priority fim_jogo > jogada_invalida > jogada_valida > expiry
  always_comb begin
    prox_estado  = estado;
    prox_dono    = dono_erro;
    prox_quem    = quem_comeca;
    prox_timeout = 1'b0;
    em_vez       = (estado == est_vez_j1) || (estado == est_vez_j2);
    case (estado)
      est_inicial, est_fim: begin
        if (iniciar) prox_estado = quem_comeca ? est_vez_j2 : est_vez_j1;
      end
      est_vez_j1, est_vez_j2: begin
        if (fim_jogo) begin
          prox_estado = est_fim;
        end else if (jogada_invalida) begin
          prox_estado = est_erro;
          prox_dono   = (estado == est_vez_j2);
        end else if (jogada_valida) begin
          prox_estado = (estado == est_vez_j1) ? est_vez_j2 : est_vez_j1;
        end else if (turno_fim) begin
          prox_estado  = (estado == est_vez_j1) ? est_vez_j2 : est_vez_j1;
          prox_timeout = 1'b1;
        end
      end
      est_erro: begin
        if (fim_jogo)      prox_estado = est_fim;
        else if (erro_fim) prox_estado = dono_erro ? est_vez_j2 : est_vez_j1;
      end
      default: prox_estado = est_inicial;
    endcase
    if ((prox_estado == est_fim) && (estado != est_fim)) prox_quem = ~quem_comeca;
    // Counters only run while their state persists, so they never wrap
    limpa_turno = (prox_estado != estado) || !em_vez;
    limpa_erro  = (prox_estado != estado) || (estado != est_erro);
    prox_saida  = decodifica(prox_estado);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jogador <= jog_nenhum;
      vez_j1  <= 1'b0;
      vez_j2  <= 1'b0;
      timeout <= 1'b0;
      em_jogo <= 1'b0;
    end else begin
      jogador <= prox_saida.jogador;
      vez_j1  <= prox_saida.vez_j1;
      vez_j2  <= prox_saida.vez_j2;
      timeout <= prox_timeout;
      em_jogo <= prox_saida.em_jogo;
    end
  end

endmodule

// File: tb/tb_controle_vez.sv
// Self-checking bench for controle_vez: directed vector table, reset corner
// cases and randomized pulses against a turn-holder model.
module tb_controle_vez;

  localparam int unsigned T = 8;
  localparam int unsigned E = 3;

  // Observed word: {jogador[1:0], vez_j1, vez_j2, timeout, em_jogo}
  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_J1   = 6'b011001;
  localparam logic [5:0] S_J2   = 6'b100101;
  localparam logic [5:0] S_ERR  = 6'b110001;
  localparam logic [5:0] S_J1T  = 6'b011011;
  localparam logic [5:0] S_J2T  = 6'b100111;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, jogada_valida, jogada_invalida, fim_jogo;
  logic [1:0] jogador;
  logic       vez_j1, vez_j2, timeout, em_jogo;
  logic [5:0] obs;

  always #5 clock = ~clock;

  controle_vez #(.TIMEOUT_CICLOS(T), .ERRO_CICLOS(E)) dut (
    .clock           (clock),
    .reset           (reset),
    .iniciar         (iniciar),
    .jogada_valida   (jogada_valida),
    .jogada_invalida (jogada_invalida),
    .fim_jogo        (fim_jogo),
    .jogador         (jogador),
    .vez_j1          (vez_j1),
    .vez_j2          (vez_j2),
    .timeout         (timeout),
    .em_jogo         (em_jogo)
  );

  assign obs = {jogador, vez_j1, vez_j2, timeout, em_jogo};

  typedef struct {
    logic       ini;
    logic       jv;
    logic       ji;
    logic       fj;
    logic [5:0] esperado;
  } vetor_t;

  vetor_t tabela[$];
  int     n_comp = 0;
  int     n_erro = 0;

  // Model: holder 0 = nobody, 1/2 = player, 3 = error display
  int m_holder, m_elapsed, m_owner, m_first;
  bit m_to;

  function automatic void add(input logic a, input logic b, input logic c,
                              input logic d, input logic [5:0] e);
    vetor_t v;
    v.ini = a; v.jv = b; v.ji = c; v.fj = d; v.esperado = e;
    tabela.push_back(v);
  endfunction

  function automatic logic [5:0] modelo_saida();
    return {2'(m_holder), m_holder == 1, m_holder == 2, m_to, m_holder != 0};
  endfunction

  task automatic modelo_reset();
    m_holder = 0; m_elapsed = 0; m_owner = 1; m_first = 1; m_to = 1'b0;
  endtask

  task automatic modelo_passo(input logic ini, input logic jv, input logic ji, input logic fj);
    m_to = 1'b0;
    if (m_holder == 0) begin
      if (ini) begin m_holder = m_first; m_elapsed = 0; end
    end else if (fj) begin
      m_holder = 0;
      m_first  = 3 - m_first;
    end else if (m_holder == 3) begin
      m_elapsed++;
      if (m_elapsed == int'(E)) begin m_holder = m_owner; m_elapsed = 0; end
    end else if (ji) begin
      m_owner = m_holder; m_holder = 3; m_elapsed = 0;
    end else if (jv) begin
      m_holder = 3 - m_holder; m_elapsed = 0;
    end else begin
      m_elapsed++;
      if (m_elapsed == int'(T)) begin
        m_holder = 3 - m_holder; m_elapsed = 0; m_to = 1'b1;
      end
    end
  endtask

  task automatic chk(input string nome, input logic [5:0] got, input logic [5:0] exp);
    n_comp++;
    if (got !== exp) begin
      n_erro++;
      $display("FAIL %s: got %b expected %b at %0t", nome, got, exp, $time);
    end
  endtask

  task automatic passo(input logic a, input logic b, input logic c, input logic d);
    @(negedge clock);
    iniciar = a; jogada_valida = b; jogada_invalida = c; fim_jogo = d;
    @(posedge clock);
    modelo_passo(a, b, c, d);
    #1;
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge
  task automatic aplica_reset(input string nome);
    @(negedge clock);
    iniciar = 0; jogada_valida = 0; jogada_invalida = 0; fim_jogo = 0;
    #1 reset = 1'b1;
    modelo_reset();
    #2 chk(nome, obs, S_IDLE);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    iniciar = 0; jogada_valida = 0; jogada_invalida = 0; fim_jogo = 0;
    modelo_reset();

    add(0,0,0,0,S_IDLE);
    add(1,0,0,0,S_J1);
    add(0,1,0,0,S_J2);
    add(0,1,0,0,S_J1);
    add(0,1,0,0,S_J2);
    for (int i = 0; i < 7; i++) add(0,0,0,0,S_J2);
    add(0,0,0,0,S_J1T);
    add(0,0,0,0,S_J1);
    add(0,0,1,0,S_ERR);
    add(0,0,0,0,S_ERR);
    add(0,0,0,0,S_ERR);
    add(0,0,0,0,S_J1);
    for (int i = 0; i < 7; i++) add(0,0,0,0,S_J1);
    add(0,0,0,0,S_J2T);
    add(0,1,0,1,S_IDLE);
    add(0,0,0,1,S_IDLE);
    add(1,0,0,0,S_J2);
    add(0,1,1,0,S_ERR);
    add(0,1,0,0,S_ERR);
    add(0,0,1,0,S_ERR);
    add(0,0,0,0,S_J2);
    add(1,0,0,0,S_J2);
    add(0,0,0,1,S_IDLE);
    add(1,0,0,0,S_J1);
    add(0,1,1,0,S_ERR);
    add(0,0,0,1,S_IDLE);
    add(1,0,0,0,S_J2);

    repeat (2) @(negedge clock);
    chk("reset_values", obs, S_IDLE);
    reset = 1'b0;

    foreach (tabela[i]) begin
      passo(tabela[i].ini, tabela[i].jv, tabela[i].ji, tabela[i].fj);
      chk($sformatf("vec%0d", i), obs, tabela[i].esperado);
    end

    // Reset while the error indication is showing
    passo(0,0,1,0);
    chk("erro_antes_reset", obs, S_ERR);
    aplica_reset("reset_async_erro");

    // Pulses while reset is held are ignored
    @(negedge clock);
    reset = 1'b1; iniciar = 1'b1;
    @(posedge clock);
    #1 chk("ini_durante_reset", obs, S_IDLE);
    @(negedge clock);
    reset = 1'b0; iniciar = 1'b0;
    passo(0,0,0,0);
    chk("ocioso_pos_reset", obs, S_IDLE);
    passo(1,0,0,0);
    chk("quem_comeca_reset", obs, S_J1);

    // Randomized pulses against the model, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        aplica_reset("reset_aleat");
      end else begin
        passo($urandom_range(3) == 0, $urandom_range(11) == 0,
              $urandom_range(29) == 0, $urandom_range(59) == 0);
        chk("aleat", obs, modelo_saida());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_erro);
    $finish;
  end

endmodule

// File: doc/controle_vez.md
CONTROLE_VEZ -- requirements
Module: controle_vez

Interface
REQ-001 Parameter TIMEOUT_CICLOS, default 5000: clock cycles a player may hold the turn before losing it.
REQ-002 Parameter ERRO_CICLOS, default 1000: clock cycles the error indication is held.
REQ-003 clock  input  1  single system clock, rising-edge active.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 iniciar  input  1  one-cycle pulse; starts a game from INICIAL or FIM.
REQ-006 jogada_valida  input  1  one-cycle pulse; current player completed a legal move.
REQ-007 jogada_invalida  input  1  one-cycle pulse; current player attempted an illegal move.
REQ-008 fim_jogo  input  1  one-cycle pulse; board logic reports win or draw.
REQ-009 jogador  output  2  turn code for the player display: 00 idle/dash, 01 player 1, 10 player 2, 11 error (E).
REQ-010 vez_j1, vez_j2  output  1 each  high while the respective player holds the turn.
REQ-011 timeout  output  1  one-cycle pulse when a turn expires.
REQ-012 em_jogo  output  1  high in VEZ_J1, VEZ_J2 and ERRO.

Function
REQ-013 FSM states: INICIAL, VEZ_J1, VEZ_J2, ERRO, FIM.
REQ-014 All outputs registered; each output reflects the new state in the cycle after the triggering input edge (1-cycle latency).
REQ-015 INICIAL/FIM + iniciar -> VEZ_J1 if quem_comeca=0, else VEZ_J2; turn counter cleared.
REQ-016 VEZ_Jx + jogada_valida -> other player's VEZ state; turn counter cleared.
REQ-017 VEZ_Jx + jogada_invalida -> ERRO; the interrupted player is stored in a 1-bit register dono_erro; error counter cleared.
REQ-018 VEZ_Jx, no event, turn counter = TIMEOUT_CICLOS-1 -> other player's VEZ state, timeout=1 for exactly one cycle, counter cleared.
REQ-019 ERRO: error counter increments each cycle; at ERRO_CICLOS-1 -> VEZ state of dono_erro, turn counter cleared (restarting that player's full turn time).
REQ-020 ERRO ignores jogada_valida and jogada_invalida; fim_jogo still honored.
REQ-021 Any non-INICIAL/FIM state + fim_jogo -> FIM.
REQ-022 Same-cycle priority: fim_jogo > jogada_invalida > jogada_valida > timeout expiry; lower-priority events that cycle are discarded and timeout does not pulse.
REQ-023 iniciar is ignored in VEZ_J1, VEZ_J2 and ERRO.
REQ-024 quem_comeca toggles on every entry to FIM, so starting player alternates between games.
REQ-025 jogador: INICIAL/FIM=00, VEZ_J1=01, VEZ_J2=10, ERRO=11; vez_j1/vez_j2 both 0 in ERRO, INICIAL, FIM.
REQ-026 Counters sized $clog2 of their parameter (minimum 1 bit), saturate never reached: cleared on every state change, so no wrap-around.
REQ-027 Parameters of 1 are legal: expiry on the first cycle in the state.

Reset
REQ-028 reset asserted at any time, mid-turn or mid-error, forces INICIAL asynchronously.
REQ-029 Reset values: jogador=00, vez_j1=0, vez_j2=0, timeout=0, em_jogo=0, counters=0, dono_erro=0, quem_comeca=0.
REQ-030 Input pulses coincident with reset deassertion edge are ignored.

Structure
REQ-031 jogador codes (00/01/10/11) and state encodings are defined as constants in the shared jogo_constantes include file, reused by the display decoder.
REQ-032 One sub-module: contador_timeout, a clearable up-counter with parameterized terminal count and a "fim" flag, instantiated twice (turn, error).

Verification (TIMEOUT_CICLOS=8, ERRO_CICLOS=3)
REQ-033 Reset, iniciar -> next cycle jogador=01, vez_j1=1, em_jogo=1.
REQ-034 In VEZ_J1 pulse jogada_valida -> jogador=10; pulse again -> jogador=01.
REQ-035 In VEZ_J2 idle 8 cycles -> timeout pulses once, jogador=01 thereafter.
REQ-036 In VEZ_J1 pulse jogada_invalida -> jogador=11 for exactly 3 cycles, then 01 with fresh 8-cycle turn.
REQ-037 jogada_valida and fim_jogo same cycle -> jogador=00, em_jogo=0; next iniciar -> jogador=10 (quem_comeca toggled).
REQ-038 reset asserted during ERRO -> jogador=00 immediately, no clock edge required.
